alu_arbiter: RTL and testbench

Shares the single registered 8-bit ALU between two requesters, for example the execute stage and the address/branch unit.
- Arbitrates requests round-robin and drives the ALU operand and function inputs for each accepted request.
- Captures the ALU result at the correct cycle and returns it to the winning requester with its own zero and error flags.
- Computes the zero flag itself because the ALU's own zero output lags by one operation and is not used.

---
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered 8-bit ALU between two requesters.
// Each accepted request takes 3 cycles; the response is routed back to its owner.
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [1:0]       req0_fn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [1:0]       req1_fn,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [1:0]       alu_fn,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             owner_p0;
  logic             err_p0;
  logic             grant1;
  logic             accept;
  logic             any_valid;
  logic [WIDTH-1:0] sel_op1, sel_op2;
  logic [1:0]       sel_fn;
  logic             sel_dz;
  logic             capt0, capt1;

  function automatic logic [WIDTH-1:0] fmt_result(input logic err, input logic [WIDTH-1:0] res);
    return err ? {WIDTH{1'b1}} : res;
  endfunction

  function automatic logic fmt_zero(input logic err, input logic [WIDTH-1:0] res);
    return !err && (res == '0);
  endfunction

  assign any_valid = req0_valid | req1_valid;
  // last_grant == 0 means req0 won last time, so req1 takes a tie.
  assign grant1    = req1_valid & (~req0_valid | ~last_grant);

  assign sel_op1 = grant1 ? req1_op1 : req0_op1;
  assign sel_op2 = grant1 ? req1_op2 : req0_op2;
  assign sel_fn  = grant1 ? req1_fn  : req0_fn;
  assign sel_dz  = (sel_fn == 2'd3) && (sel_op2 == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (state != IDLE);
    if (rst_n && state == IDLE) begin
      req0_ready = req0_valid & ~grant1;
      req1_ready = grant1;
    end
  end

  assign accept = req0_ready | req1_ready;
  assign capt0  = (state == CAPT) && !owner_p0;
  assign capt1  = (state == CAPT) &&  owner_p0;

  // Accept: load the ALU drive; a divide by zero is turned into 0 + op1 so the ALU never sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_fn     <= '0;
      owner_p0   <= 1'b0;
      err_p0     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_op1    <= sel_op1;
      alu_op2    <= sel_dz ? '0 : sel_op2;
      alu_fn     <= sel_dz ? 2'd0 : sel_fn;
      owner_p0   <= grant1;
      err_p0     <= sel_dz;
      last_grant <= grant1;
    end
  end

  // Capture: ALU result is valid in CAPT; route it to the owner only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp0_err    <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
      rsp1_err    <= 1'b0;
    end else begin
      rsp0_valid <= capt0;
      rsp1_valid <= capt1;
      if (capt0) begin
        rsp0_result <= fmt_result(err_p0, alu_result);
        rsp0_zero   <= fmt_zero(err_p0, alu_result);
        rsp0_err    <= err_p0;
      end
      if (capt1) begin
        rsp1_result <= fmt_result(err_p0, alu_result);
        rsp1_zero   <= fmt_zero(err_p0, alu_result);
        rsp1_err    <= err_p0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table-driven single requests plus hand-written
// backpressure, reset-mid-operation and contention sequences.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [1:0] req0_fn = '0, req1_fn = '0;
  logic       rsp0_valid, rsp0_zero, rsp0_err, rsp1_valid, rsp1_zero, rsp1_err;
  logic [7:0] rsp0_result, rsp1_result;
  logic [7:0] alu_op1, alu_op2, alu_result;
  logic [1:0] alu_fn;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_fn(req0_fn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_fn(req1_fn),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .rsp1_err(rsp1_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_fn(alu_fn),
    .alu_result(alu_result), .busy(busy)
  );

  // Registered ALU stand-in.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] fn);
    logic [15:0] p;
    case (fn)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin p = a * b; return p[7:0]; end
      default: return (b == 8'd0) ? 8'hFF : a / b;
    endcase
  endfunction

  always_ff @(posedge clk) alu_result <= alu_f(alu_op1, alu_op2, alu_fn);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit port, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] fn);
    if (port) begin
      req1_valid = v; req1_op1 = a; req1_op2 = b; req1_fn = fn;
    end else begin
      req0_valid = v; req0_op1 = a; req0_op2 = b; req0_fn = fn;
    end
  endtask

  typedef struct {
    string      name;
    bit         port;
    logic [7:0] op1, op2;
    logic [1:0] fn;
    logic [1:0] exp_alu_fn;
    logic [7:0] exp_alu_op2;
    logic [7:0] exp_result;
    logic       exp_zero, exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_one(input vec_t v);
    int  n;
    logic rdy;
    @(negedge clk);
    drive(v.port, 1'b1, v.op1, v.op2, v.fn);
    #1;
    n = 0;
    rdy = v.port ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1; n++;
      rdy = v.port ? req1_ready : req0_ready;
    end
    chk({v.name, "_ready"}, rdy, 1'b1);
    if (!rdy) begin
      drive(v.port, 1'b0, v.op1, v.op2, v.fn);
      return;
    end
    @(posedge clk); #1;
    drive(v.port, 1'b0, 8'h00, 8'h00, 2'd0);
    @(negedge clk); #1;
    chk({v.name, "_exec_fn"}, alu_fn, v.exp_alu_fn);
    chk({v.name, "_exec_op2"}, alu_op2, v.exp_alu_op2);
    chk({v.name, "_exec_busy"}, busy, 1'b1);
    @(negedge clk); #1;
    chk({v.name, "_capt_novalid"}, {rsp1_valid, rsp0_valid}, 2'b00);
    @(negedge clk); #1;
    chk({v.name, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, v.port ? 2'b10 : 2'b01);
    chk({v.name, "_result"}, v.port ? rsp1_result : rsp0_result, v.exp_result);
    chk({v.name, "_zero"}, v.port ? rsp1_zero : rsp0_zero, v.exp_zero);
    chk({v.name, "_err"}, v.port ? rsp1_err : rsp0_err, v.exp_err);
    @(negedge clk); #1;
    chk({v.name, "_pulse_end"}, {rsp1_valid, rsp0_valid, busy}, 3'b000);
  endtask

  initial begin
    vecs[0] = '{"add20_13", 1'b0, 8'd20,  8'd13, 2'd0, 2'd0, 8'd13, 8'd33,  1'b0, 1'b0};
    vecs[1] = '{"sub5_5",   1'b1, 8'd5,   8'd5,  2'd1, 2'd1, 8'd5,  8'd0,   1'b1, 1'b0};
    vecs[2] = '{"mul16_16", 1'b1, 8'd16,  8'd16, 2'd2, 2'd2, 8'd16, 8'd0,   1'b1, 1'b0};
    vecs[3] = '{"mul20_13", 1'b1, 8'd20,  8'd13, 2'd2, 2'd2, 8'd13, 8'd4,   1'b0, 1'b0};
    vecs[4] = '{"sub3_5",   1'b0, 8'd3,   8'd5,  2'd1, 2'd1, 8'd5,  8'd254, 1'b0, 1'b0};
    vecs[5] = '{"div9_0",   1'b0, 8'd9,   8'd0,  2'd3, 2'd0, 8'd0,  8'hFF,  1'b0, 1'b1};
    vecs[6] = '{"div200_7", 1'b0, 8'd200, 8'd7,  2'd3, 2'd3, 8'd7,  8'd28,  1'b0, 1'b0};
    vecs[7] = '{"add255_1", 1'b1, 8'd255, 8'd1,  2'd0, 2'd0, 8'd1,  8'd0,   1'b1, 1'b0};

    // Reset state, with a request already pending.
    req0_valid = 1'b1;
    #12;
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp", {rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
                    rsp1_valid, rsp1_result, rsp1_zero, rsp1_err}, '0);
    chk("rst_alu", {alu_op1, alu_op2, alu_fn}, '0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_one(vecs[i]);

    // Backpressure: req1 arrives during a req0 operation and must wait.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd1, 8'd2, 2'd0);
    #1;
    chk("bp_r0_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 2'd0);
    drive(1'b1, 1'b1, 8'd10, 8'd3, 2'd1);
    @(negedge clk); #1;
    chk("bp_exec_r1_ready", req1_ready, 1'b0);
    @(negedge clk); #1;
    chk("bp_capt_r1_ready", req1_ready, 1'b0);
    @(negedge clk); #1;
    chk("bp_idle_r1_ready", req1_ready, 1'b1);
    chk("bp_rsp0_valid", {rsp1_valid, rsp0_valid}, 2'b01);
    chk("bp_rsp0_result", rsp0_result, 8'd3);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 8'd0, 8'd0, 2'd0);
    @(negedge clk); #1;
    chk("bp_alu_payload", {alu_op1, alu_op2, alu_fn}, {8'd10, 8'd3, 2'd1});
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("bp_rsp1_valid", {rsp1_valid, rsp0_valid}, 2'b10);
    chk("bp_rsp1_result", rsp1_result, 8'd7);
    chk("bp_rsp0_held", rsp0_result, 8'd3);

    // Reset asserted during CAPT: nothing comes back.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd1, 8'd1, 2'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rsp", {rsp0_valid, rsp0_result, rsp0_err, rsp1_valid, rsp1_result, rsp1_err}, '0);
    chk("mid_rst_alu", {alu_op1, alu_op2, alu_fn}, '0);
    drive(1'b0, 1'b1, 8'd7, 8'd8, 2'd0);
    drive(1'b1, 1'b1, 8'd50, 8'd8, 2'd1);
    #1;
    chk("mid_rst_ready", {req1_ready, req0_ready}, 2'b00);
    @(negedge clk); #1;
    chk("mid_rst_no_pulse", {rsp1_valid, rsp0_valid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Contention from reset: grants alternate 0,1,0,1, one accept every 3 cycles.
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont%0d_grant", k), {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
      @(posedge clk);
      @(negedge clk); #1;
      chk($sformatf("cont%0d_exec_ready", k), {req1_ready, req0_ready}, 2'b00);
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk($sformatf("cont%0d_rsp_valid", k), {rsp1_valid, rsp0_valid}, (k % 2) ? 2'b10 : 2'b01);
      chk($sformatf("cont%0d_result", k), (k % 2) ? rsp1_result : rsp0_result,
          (k % 2) ? 8'd42 : 8'd15);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0, 2'd0);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 2'd0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
